hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter WAIT_TIMEOUT, default 255: consecutive memory-wait cycles before the fatal timeout.
REQ-002 clock  in  1  clock; all state updates on posedge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 d_rs, d_rt  in  5 each  decode-stage source register addresses; d_is_branch  in  1  decode holds a branch.
REQ-005 e_ra0, e_ra1, e_rf_wa  in  5 each  execute-stage sources and destination; e_rf_we, e_is_load  in  1 each.
REQ-006 m_rf_wa  in  5; m_rf_we, m_is_load, m_sel_pc, m_dmem_req  in  1 each  (m_sel_pc = taken branch resolved in M).
REQ-007 w_rf_wa  in  5; w_rf_we  in  1.
REQ-008 dmem_ready  in  1  data memory completes the M-stage access this cycle; perf_clear  in  1  synchronous counter clear.
REQ-009 f_stall, d_stall, e_stall, m_stall  out  1 each  hold the corresponding pipeline register.
REQ-010 d_flush, e_flush, m_flush, w_bubble  out  1 each  load zero into the corresponding register.
REQ-011 fwd_a_e, fwd_b_e  out  2 each  ALU operand select: 00 register file, 01 writeback, 10 memory.
REQ-012 fwd_a_d, fwd_b_d  out  1 each  branch-compare operand from M-stage ALU result.
REQ-013 mem_timeout  out  1  sticky fatal error; stall_cycles  out  32; flush_events  out  16.

Function
REQ-014 All stall/flush/forward outputs SHALL be combinational from inputs and current state (zero-cycle latency); state and counters SHALL be registered.
REQ-015 fwd_a_e SHALL be 10 if e_ra0!=0, m_rf_we, and m_rf_wa==e_ra0; else 01 if e_ra0!=0, w_rf_we, and w_rf_wa==e_ra0; else 00; fwd_b_e identical using e_ra1.
REQ-016 fwd_a_d SHALL be 1 iff d_rs!=0, m_rf_we, and m_rf_wa==d_rs; fwd_b_d identical using d_rt.
REQ-017 load_use SHALL be e_is_load & e_rf_we & e_rf_wa!=0 & (e_rf_wa==d_rs | e_rf_wa==d_rt).
REQ-018 branch_haz SHALL be d_is_branch & ((e_rf_we & e_rf_wa!=0 & e_rf_wa matches d_rs or d_rt) | (m_is_load & m_rf_we & m_rf_wa!=0 & m_rf_wa matches d_rs or d_rt)).
REQ-019 Register 0 SHALL never cause a forward or stall.
REQ-020 FSM states RUN, MEM_WAIT, ERROR; reset state RUN.
REQ-021 RUN -> MEM_WAIT when m_dmem_req & !dmem_ready; MEM_WAIT -> RUN when dmem_ready; MEM_WAIT -> ERROR when wait counter reaches WAIT_TIMEOUT with !dmem_ready; ERROR exits only on reset.
REQ-022 mem_stall = (m_dmem_req & !dmem_ready) in RUN or MEM_WAIT, or state==ERROR.
REQ-023 Under mem_stall: f/d/e/m_stall=1, w_bubble=1, all flushes=0.
REQ-024 Wait counter (8+ bits) SHALL clear on entry to MEM_WAIT and increment once per MEM_WAIT cycle.
REQ-025 Taken branch (m_sel_pc=1, no mem_stall): d_flush=e_flush=m_flush=1 for that cycle, all stalls=0 (flush beats load_use/branch_haz).
REQ-026 m_sel_pc during mem_stall SHALL set a pending flag; flushes SHALL be issued in the first cycle mem_stall deasserts, then the flag SHALL clear.
REQ-027 load_use|branch_haz (no mem_stall, no flush): f_stall=d_stall=1, e_flush=1; m/w unaffected.
REQ-028 stall_cycles SHALL increment each cycle f_stall=1, saturating at 0xFFFFFFFF; flush_events SHALL increment per flush issue, saturating at 0xFFFF.
REQ-029 perf_clear SHALL zero both counters next edge, taking priority over increment; it SHALL not affect FSM or mem_timeout.
REQ-030 mem_timeout SHALL equal (state==ERROR).

Reset
REQ-031 While reset=1: state RUN, wait counter 0, pending flag 0, counters 0, mem_timeout 0; with all data inputs 0 every output SHALL be 0.
REQ-032 Reset asserted in MEM_WAIT or ERROR SHALL return to RUN immediately, discarding pending flush.

Verification
REQ-033 e_ra0=5, m_rf_we=1, m_rf_wa=5, w_rf_we=1, w_rf_wa=5 -> fwd_a_e=10; drop m_rf_we -> 01; set e_ra0=0 -> 00.
REQ-034 e_is_load=1, e_rf_we=1, e_rf_wa=7, d_rt=7 -> f_stall=d_stall=e_flush=1, stall_cycles +1 per cycle.
REQ-035 m_dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> all stalls and w_bubble high 3 cycles, state RUN after ready, stall_cycles=3.
REQ-036 WAIT_TIMEOUT=4, dmem_ready held 0 -> ERROR after 4 MEM_WAIT cycles, mem_timeout=1 held until reset.
REQ-037 m_sel_pc=1 during memory wait, ready 2 cycles later -> d/e/m_flush pulse exactly once in ready cycle, flush_events=1.
REQ-038 m_sel_pc=1 together with load_use -> flushes=1, f_stall=d_stall=0.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard control: operand forwarding, load-use/branch interlocks, taken-branch
// flushes, data-memory wait FSM with fatal timeout, and stall/flush performance counters.
module hazard_unit #(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_is_branch,
    input  logic [4:0]  e_ra0,
    input  logic [4:0]  e_ra1,
    input  logic [4:0]  e_rf_wa,
    input  logic        e_rf_we,
    input  logic        e_is_load,
    input  logic [4:0]  m_rf_wa,
    input  logic        m_rf_we,
    input  logic        m_is_load,
    input  logic        m_sel_pc,
    input  logic        m_dmem_req,
    input  logic [4:0]  w_rf_wa,
    input  logic        w_rf_we,
    input  logic        dmem_ready,
    input  logic        perf_clear,
    output logic        f_stall,
    output logic        d_stall,
    output logic        e_stall,
    output logic        m_stall,
    output logic        d_flush,
    output logic        e_flush,
    output logic        m_flush,
    output logic        w_bubble,
    output logic [1:0]  fwd_a_e,
    output logic [1:0]  fwd_b_e,
    output logic        fwd_a_d,
    output logic        fwd_b_d,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events
);
    localparam int CW = (WAIT_TIMEOUT > 255) ? $clog2(WAIT_TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            pend_q, pend_d;
    logic [31:0]     stall_cnt_q;
    logic [15:0]     flush_cnt_q;

    logic m_fwd_ok, w_fwd_ok, e_dst_ok, m_ld_ok;
    logic load_use, branch_haz, mem_stall, redirect;

    // Register 0 is hardwired zero, so a write to it is never a real producer.
    assign m_fwd_ok = m_rf_we && (m_rf_wa != 5'd0);
    assign w_fwd_ok = w_rf_we && (w_rf_wa != 5'd0);
    assign e_dst_ok = e_rf_we && (e_rf_wa != 5'd0);
    assign m_ld_ok  = m_is_load && m_fwd_ok;

    assign fwd_a_e = (m_fwd_ok && m_rf_wa == e_ra0) ? 2'b10 :
                     (w_fwd_ok && w_rf_wa == e_ra0) ? 2'b01 : 2'b00;
    assign fwd_b_e = (m_fwd_ok && m_rf_wa == e_ra1) ? 2'b10 :
                     (w_fwd_ok && w_rf_wa == e_ra1) ? 2'b01 : 2'b00;
    assign fwd_a_d = m_fwd_ok && (m_rf_wa == d_rs);
    assign fwd_b_d = m_fwd_ok && (m_rf_wa == d_rt);

    assign load_use   = e_is_load && e_dst_ok && (e_rf_wa == d_rs || e_rf_wa == d_rt);
    assign branch_haz = d_is_branch &&
                        ((e_dst_ok && (e_rf_wa == d_rs || e_rf_wa == d_rt)) ||
                         (m_ld_ok  && (m_rf_wa == d_rs || m_rf_wa == d_rt)));

    assign mem_stall = (state_q == ERROR) || (m_dmem_req && !dmem_ready);
    // A redirect seen while frozen is replayed on the first unfrozen cycle.
    assign redirect  = !mem_stall && (m_sel_pc || pend_q);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            RUN: begin
                if (m_dmem_req && !dmem_ready) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = '0;
                end
            end
            MEM_WAIT: begin
                wcnt_d = wcnt_q + 1'b1;
                if (dmem_ready)
                    state_d = RUN;
                else if (wcnt_d == CW'(WAIT_TIMEOUT))
                    state_d = ERROR;
            end
            default: state_d = ERROR;
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        if (mem_stall && m_sel_pc)
            pend_d = 1'b1;
        else if (redirect)
            pend_d = 1'b0;
    end

    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        e_stall  = 1'b0;
        m_stall  = 1'b0;
        d_flush  = 1'b0;
        e_flush  = 1'b0;
        m_flush  = 1'b0;
        w_bubble = 1'b0;
        if (mem_stall) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_stall  = 1'b1;
            m_stall  = 1'b1;
            w_bubble = 1'b1;
        end else if (redirect) begin
            d_flush = 1'b1;
            e_flush = 1'b1;
            m_flush = 1'b1;
        end else if (load_use || branch_haz) begin
            f_stall = 1'b1;
            d_stall = 1'b1;
            e_flush = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            pend_q  <= pend_d;
        end
    end

    // flush_events counts taken-branch redirects only, not interlock bubbles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (perf_clear) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (f_stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign mem_timeout  = (state_q == ERROR);
    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
endmodule
